// File: rtl/stream_block_source.sv
// stream_block_source
// Replays a preloaded sequence of data blocks as an HWPE-style valid/ready
// stream. Pacing between beats is selectable: back-to-back, a fixed number
// of idle cycles, or a pseudo-random idle gap driven by a 16-bit LFSR.
//
// Optional feature macro: STREAM_BLOCK_SOURCE_STRB_ZERO_MASK_EN
//   defined   : strobe bytes of an all-zero item are cleared
//   undefined : strobe is all ones whenever valid_o is high
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   clear_i            synchronous soft clear back to IDLE
//   start_i            start pulse (sampled in IDLE or DONE)
//   num_blocks_i       beats to send, sampled on start
//   mode_i             pacing: 0 back-to-back, 1 fixed gap, 2 random, 3 as 0
//   gap_i              idle cycles between beats in mode 1
//   load_we_i/addr/data preload port, honoured only in IDLE or DONE
//   valid_o/ready_i    stream handshake
//   data_o, strb_o     stream payload and byte strobe
//   count_o            handshakes completed since start
//   busy_o, done_o     transfer in progress / all beats accepted
module stream_block_source #(
    parameter int          ITEM_SIZE   = 32,
    parameter int          BLOCK_ITEMS = 4,
    parameter int          DEPTH       = 64,
    parameter int          GAP_W       = 5,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clear_i,
    input  logic                                  start_i,
    input  logic [$clog2(DEPTH):0]                num_blocks_i,
    input  logic [1:0]                            mode_i,
    input  logic [GAP_W-1:0]                      gap_i,
    input  logic                                  load_we_i,
    input  logic [$clog2(DEPTH)-1:0]              load_addr_i,
    input  logic [ITEM_SIZE*BLOCK_ITEMS-1:0]      load_data_i,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output logic [ITEM_SIZE*BLOCK_ITEMS-1:0]      data_o,
    output logic [ITEM_SIZE*BLOCK_ITEMS/8-1:0]    strb_o,
    output logic [$clog2(DEPTH):0]                count_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int DW = ITEM_SIZE * BLOCK_ITEMS;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = DW / 8;
    localparam int IB = ITEM_SIZE / 8;

    localparam logic [AW-1:0]    IDX_ONE = 1;
    localparam logic [CW-1:0]    CNT_ONE = 1;
    localparam logic [GAP_W-1:0] GAP_ONE = 1;

    typedef enum logic [1:0] {IDLE, VALID, GAP, DONE} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     mem [DEPTH];
    logic [AW-1:0]     idx_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     num_q;
    logic [1:0]        mode_q;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [15:0]       lfsr_q;

    logic              can_start;
    logic              handshake;
    logic [CW-1:0]     count_inc;
    logic              lfsr_fb;

    assign can_start = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign handshake = (state_q == VALID) && ready_i;
    assign count_inc = count_q + CNT_ONE;
    // Taps 16,14,13,11 of x^16+x^14+x^13+x^11+1, shifting left into bit 0.
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    if (num_blocks_i == '0) state_d = DONE;
                    else                    state_d = VALID;
                end
            end
            VALID: begin
                if (ready_i) begin
                    if (count_inc == num_q)                        state_d = DONE;
                    else if (mode_q == 2'd1 && gap_q != '0)        state_d = GAP;
                    else if (mode_q == 2'd2)                       state_d = GAP;
                    else                                           state_d = VALID;
                end
            end
            GAP: begin
                // The <= guards a zero counter so the FSM can never stall here.
                if (mode_q == 2'd1) begin
                    if (gap_cnt_q <= GAP_ONE) state_d = VALID;
                end else if (mode_q == 2'd2) begin
                    if (lfsr_q[1:0] != 2'b00) state_d = VALID;
                end else begin
                    state_d = VALID;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    // Transfer bookkeeping: configuration latch, beat index, handshake count,
    // fixed-gap counter and the random-gap LFSR.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q     <= '0;
            count_q   <= '0;
            num_q     <= '0;
            mode_q    <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            lfsr_q    <= LFSR_SEED;
        end else if (clear_i) begin
            idx_q     <= '0;
            count_q   <= '0;
            gap_cnt_q <= '0;
        end else begin
            if (can_start) begin
                num_q   <= num_blocks_i;
                mode_q  <= mode_i;
                gap_q   <= gap_i;
                idx_q   <= '0;
                count_q <= '0;
            end
            if (handshake) begin
                count_q   <= count_inc;
                idx_q     <= idx_q + IDX_ONE;
                gap_cnt_q <= gap_q;
            end
            if (state_q == GAP) begin
                if (mode_q == 2'd1) gap_cnt_q <= gap_cnt_q - GAP_ONE;
                if (mode_q == 2'd2) lfsr_q    <= {lfsr_q[14:0], lfsr_fb};
            end
        end
    end

    // Block storage is deliberately outside the reset domain so a reset
    // does not wipe the preloaded sequence.
    always_ff @(posedge clk_i) begin
        if (load_we_i && ((state_q == IDLE) || (state_q == DONE)))
            mem[load_addr_i] <= load_data_i;
    end

    assign valid_o = (state_q == VALID);
    assign busy_o  = (state_q == VALID) || (state_q == GAP);
    assign done_o  = (state_q == DONE);
    assign count_o = count_q;
    assign data_o  = valid_o ? mem[idx_q] : '0;

`ifdef STREAM_BLOCK_SOURCE_STRB_ZERO_MASK_EN
    // data_o is already zero while not valid, so masked strobes drop to zero too.
    for (genvar i = 0; i < BLOCK_ITEMS; i++) begin : g_strb
        assign strb_o[i*IB +: IB] = {IB{|data_o[i*ITEM_SIZE +: ITEM_SIZE]}};
    end
`else
    assign strb_o = {SW{valid_o}};
`endif

endmodule

// File: tb/tb_stream_block_source.sv
// tb_stream_block_source
// Directed bench for stream_block_source. Stimulus pushes the expected beats
// into a scoreboard queue; a monitor pops and compares on every handshake.
module tb_stream_block_source;

    localparam int DEPTH = 64;
    localparam int DW    = 128;
    localparam int SW    = 16;
    localparam int AW    = 6;
    localparam int CW    = 7;
    localparam int GAP_W = 5;

`ifdef STREAM_BLOCK_SOURCE_STRB_ZERO_MASK_EN
    localparam logic [SW-1:0] SPECIAL_STRB = 16'hF0F0;
`else
    localparam logic [SW-1:0] SPECIAL_STRB = 16'hFFFF;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } beat_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             clear_i;
    logic             start_i;
    logic [CW-1:0]    num_blocks_i;
    logic [1:0]       mode_i;
    logic [GAP_W-1:0] gap_i;
    logic             load_we_i;
    logic [AW-1:0]    load_addr_i;
    logic [DW-1:0]    load_data_i;
    logic             valid_o;
    logic             ready_i;
    logic [DW-1:0]    data_o;
    logic [SW-1:0]    strb_o;
    logic [CW-1:0]    count_o;
    logic             busy_o;
    logic             done_o;

    int    passCount  = 0;
    int    totalCount = 0;
    beat_t sbq[$];
    int    idleRuns[$];
    int    expGaps[$];

    stream_block_source #(
        .ITEM_SIZE(32), .BLOCK_ITEMS(4), .DEPTH(DEPTH), .GAP_W(GAP_W),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .num_blocks_i(num_blocks_i), .mode_i(mode_i), .gap_i(gap_i),
        .load_we_i(load_we_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .strb_o(strb_o),
        .count_o(count_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // Item j of block k is {A5, k, 00, j+1}: never zero, so the strobe is full.
    function automatic logic [DW-1:0] blockVal(input int k);
        logic [DW-1:0] v;
        for (int j = 0; j < 4; j++)
            v[j*32 +: 32] = {8'hA5, 8'(k), 8'h00, 8'(j + 1)};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic pushExp(input int k);
        beat_t b;
        b.data = blockVal(k);
        b.strb = '1;
        sbq.push_back(b);
    endtask

    task automatic loadBlock(input int addr, input logic [DW-1:0] d);
        load_we_i   = 1'b1;
        load_addr_i = AW'(addr);
        load_data_i = d;
        step();
        load_we_i   = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input int m, input int g);
        start_i      = 1'b1;
        num_blocks_i = CW'(n);
        mode_i       = 2'(m);
        gap_i        = GAP_W'(g);
        step();
        start_i      = 1'b0;
    endtask

    // Called right after applyStimulus; cycles counts edges since start.
    task automatic runToDone(input int budget, output int cycles);
        int run;
        bit seen;
        run = 0;
        seen = 0;
        cycles = 1;
        idleRuns.delete();
        while (!done_o && cycles < budget) begin
            if (valid_o) begin
                if (seen) idleRuns.push_back(run);
                run = 0;
                seen = 1;
            end else begin
                run++;
            end
            step();
            cycles++;
        end
        if (!done_o) checkOutput("done_timeout", {127'b0, done_o}, 128'd1);
    endtask

    function automatic logic [15:0] lfsrAdv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Scoreboard monitor: samples just after the negedge, once inputs settle.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (valid_o && ready_i && !rst_i) begin
                if (sbq.size() == 0) begin
                    totalCount++;
                    $display("[TB] FAIL unexpected_beat: got data %0h with no beat expected", data_o);
                end else begin
                    beat_t b;
                    b = sbq.pop_front();
                    checkOutput("beat_data", data_o, b.data);
                    checkOutput("beat_strb", {112'b0, strb_o}, {112'b0, b.strb});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        logic [DW-1:0] d0;
        logic [SW-1:0] s0;
        logic [15:0] l;
        int g;
        logic [1:0] pre;

        rst_i = 1'b1; clear_i = 0; start_i = 0; num_blocks_i = '0; mode_i = '0;
        gap_i = '0; load_we_i = 0; load_addr_i = '0; load_data_i = '0; ready_i = 1'b1;
        step(); step();
        checkOutput("reset_valid", {127'b0, valid_o}, 128'd0);
        checkOutput("reset_busy",  {127'b0, busy_o},  128'd0);
        checkOutput("reset_done",  {127'b0, done_o},  128'd0);
        checkOutput("reset_count", {121'b0, count_o}, 128'd0);
        rst_i = 1'b0;
        step();

        for (int k = 0; k < DEPTH; k++) loadBlock(k, blockVal(k));

        $display("[TB] mode 0, num 4");
        for (int k = 0; k < 4; k++) pushExp(k);
        applyStimulus(4, 0, 0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("m0_valid_run", {127'b0, valid_o}, 128'd1);
            step();
        end
        checkOutput("m0_done",  {127'b0, done_o},  128'd1);
        checkOutput("m0_busy",  {127'b0, busy_o},  128'd0);
        checkOutput("m0_count", {121'b0, count_o}, 128'd4);

        $display("[TB] mode 1, gap 3, num 3");
        for (int k = 0; k < 3; k++) pushExp(k);
        applyStimulus(3, 1, 3);
        runToDone(100, cyc);
        checkOutput("m1_cycles", 128'(cyc), 128'd10);
        checkOutput("m1_gap_count", 128'(idleRuns.size()), 128'd2);
        foreach (idleRuns[i]) checkOutput("m1_gap_len", 128'(idleRuns[i]), 128'd3);
        checkOutput("m1_count", {121'b0, count_o}, 128'd3);

        $display("[TB] mode 0 stall");
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) pushExp(k);
        applyStimulus(3, 0, 0);
        d0 = data_o;
        s0 = strb_o;
        checkOutput("stall_first", d0, blockVal(0));
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                load_we_i = 1'b1; load_addr_i = AW'(1); load_data_i = '1;
            end
            if (c == 2) begin
                start_i = 1'b1; num_blocks_i = CW'(1);
            end
            step();
            load_we_i = 1'b0;
            start_i = 1'b0;
            checkOutput("stall_valid", {127'b0, valid_o}, 128'd1);
            checkOutput("stall_data", data_o, d0);
            checkOutput("stall_strb", {112'b0, strb_o}, {112'b0, s0});
        end
        ready_i = 1'b1;
        runToDone(100, cyc);
        checkOutput("stall_count", {121'b0, count_o}, 128'd3);

        $display("[TB] mode 2, num 8");
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        l = 16'hACE1;
        expGaps.delete();
        for (int b = 0; b < 7; b++) begin
            g = 0;
            do begin
                g++;
                pre = l[1:0];
                l = lfsrAdv(l);
            end while (pre == 2'b00);
            expGaps.push_back(g);
        end
        for (int k = 0; k < 8; k++) pushExp(k);
        applyStimulus(8, 2, 0);
        runToDone(1000, cyc);
        checkOutput("m2_gap_count", 128'(idleRuns.size()), 128'd7);
        for (int i = 0; i < 7; i++)
            if (i < idleRuns.size())
                checkOutput("m2_gap_len", 128'(idleRuns[i]), 128'(expGaps[i]));
        checkOutput("m2_count", {121'b0, count_o}, 128'd8);

        $display("[TB] reset mid transfer");
        pushExp(0);
        applyStimulus(6, 0, 0);
        step();
        rst_i = 1'b1;
        #2;
        checkOutput("rst_valid", {127'b0, valid_o}, 128'd0);
        checkOutput("rst_busy",  {127'b0, busy_o},  128'd0);
        checkOutput("rst_done",  {127'b0, done_o},  128'd0);
        checkOutput("rst_count", {121'b0, count_o}, 128'd0);
        checkOutput("rst_data",  data_o, 128'd0);
        checkOutput("rst_strb",  {112'b0, strb_o}, 128'd0);
        step();
        rst_i = 1'b0;
        step();
        for (int k = 0; k < 6; k++) pushExp(k);
        applyStimulus(6, 0, 0);
        checkOutput("restart_count0", {121'b0, count_o}, 128'd0);
        checkOutput("restart_data0", data_o, blockVal(0));
        runToDone(100, cyc);
        checkOutput("restart_cycles", 128'(cyc), 128'd7);
        checkOutput("restart_count", {121'b0, count_o}, 128'd6);

        $display("[TB] num 0 and clear");
        applyStimulus(0, 0, 0);
        checkOutput("num0_done",  {127'b0, done_o},  128'd1);
        checkOutput("num0_valid", {127'b0, valid_o}, 128'd0);
        checkOutput("num0_count", {121'b0, count_o}, 128'd0);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        checkOutput("clear_done", {127'b0, done_o}, 128'd0);

        $display("[TB] num = DEPTH");
        for (int k = 0; k < DEPTH; k++) pushExp(k);
        applyStimulus(DEPTH, 3, 0);
        runToDone(500, cyc);
        checkOutput("full_cycles", 128'(cyc), 128'(DEPTH + 1));
        checkOutput("full_count", {121'b0, count_o}, 128'(DEPTH));

        $display("[TB] strobe masking");
        d0 = {32'h0000_0001, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
        loadBlock(0, d0);
        begin
            beat_t b;
            b.data = d0;
            b.strb = SPECIAL_STRB;
            sbq.push_back(b);
        end
        applyStimulus(1, 0, 0);
        checkOutput("special_strb", {112'b0, strb_o}, {112'b0, SPECIAL_STRB});
        runToDone(20, cyc);
        checkOutput("special_count", {121'b0, count_o}, 128'd1);

        step();
        checkOutput("scoreboard_drained", 128'(sbq.size()), 128'd0);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
